// File: rtl/lzc_pkg.sv
// Shared parameters and FSM state encoding for the lzc normaliser.
package lzc_pkg;

    localparam int WIDTH  = 8;
    localparam int WORD   = 4;
    localparam int DW     = WIDTH * WORD;
    localparam int CNT_W  = $clog2(DW) + 1;
    localparam int BEAT_W = $clog2(WORD);

    typedef logic [1:0] state_t;

    localparam state_t COLLECT  = 2'd0;
    localparam state_t WAIT_CNT = 2'd1;
    localparam state_t OUT      = 2'd2;

endpackage

// File: rtl/lzc_normalizer_if.sv
// Output handshake bundle from the normaliser to the float-pack stage.
interface lzc_normalizer_if;
    import lzc_pkg::*;

    logic [DW-1:0]    norm_data;
    logic [CNT_W-1:0] norm_shift;
    logic             norm_all;
    logic             norm_mode;
    logic             norm_valid;
    logic             norm_ready;

    modport master (
        output norm_data, norm_shift, norm_all,
        output norm_mode, norm_valid,
        input  norm_ready
    );

    modport slave (
        input  norm_data, norm_shift, norm_all,
        input  norm_mode, norm_valid,
        output norm_ready
    );

endinterface

// File: rtl/lzc_norm_shift.sv
// Log2 barrel left-shifter with count clamp and all-zeros/all-ones flag.
module lzc_norm_shift
    import lzc_pkg::*;
(
    input  logic [DW-1:0]    operand,
    input  logic [CNT_W-1:0] count,
    output logic [DW-1:0]    shifted,
    output logic [CNT_W-1:0] amount,
    output logic             all_flag,
    output logic             over
);

    always_comb begin
        over     = count > CNT_W'(DW);
        amount   = over ? CNT_W'(DW) : count;
        all_flag = amount == CNT_W'(DW);
        shifted  = operand;
        for (int i = 0; i < CNT_W - 1; i++) begin
            if (amount[i]) shifted = shifted << (1 << i);
        end
        // top bit alone means a full-width shift
        if (amount[CNT_W-1]) shifted = '0;
    end

endmodule

// File: rtl/lzc_normalizer.sv
// Assembles the operand beside lzc and normalises it by the lzc count.
// Define LZCN_ERR_EN to make err track protocol violations.
module lzc_normalizer
    import lzc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    data,
    input  logic                Ivalid,
    input  logic                mode,
    input  logic [CNT_W-1:0]    zeros,
    input  logic                Ovalid,
    lzc_normalizer_if.master    out_if,
    output logic                err
);

`ifdef LZCN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]     op_q, op_d;
    logic              mode_q, mode_d;
    logic [DW-1:0]     ndata_q, ndata_d;
    logic [CNT_W-1:0]  nshift_q, nshift_d;
    logic              nall_q, nall_d;
    logic              nmode_q, nmode_d;
    logic              nvalid_q, nvalid_d;
    logic              err_q, err_d;
    logic              hit;

    logic [DW-1:0]     sh_data;
    logic [CNT_W-1:0]  sh_amt;
    logic              sh_all;
    logic              sh_over;

    lzc_norm_shift u_shift (
        .operand  (op_q),
        .count    (zeros),
        .shifted  (sh_data),
        .amount   (sh_amt),
        .all_flag (sh_all),
        .over     (sh_over)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        mode_d   = mode_q;
        ndata_d  = ndata_q;
        nshift_d = nshift_q;
        nall_d   = nall_q;
        nmode_d  = nmode_q;
        nvalid_d = nvalid_q;
        hit      = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (Ivalid) begin
                    op_d = {op_q[DW-WIDTH-1:0], data};
                    if (cnt_q == '0) mode_d = mode;
                    if (cnt_q == BEAT_W'(WORD - 1)) begin
                        cnt_d   = '0;
                        state_d = WAIT_CNT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (Ovalid) hit = 1'b1;
            end
            WAIT_CNT: begin
                if (Ivalid) hit = 1'b1;
                if (Ovalid) begin
                    ndata_d  = sh_data;
                    nshift_d = sh_amt;
                    nall_d   = sh_all;
                    nmode_d  = mode_q;
                    nvalid_d = 1'b1;
                    state_d  = OUT;
                    if (sh_over) hit = 1'b1;
                end
            end
            OUT: begin
                // a beat arriving on the transfer cycle is still dropped
                if (Ivalid || Ovalid) hit = 1'b1;
                if (nvalid_q && out_if.norm_ready) begin
                    nvalid_d = 1'b0;
                    state_d  = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        err_d = err_q | (ERR_EN & hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            op_q     <= '0;
            mode_q   <= 1'b0;
            ndata_q  <= '0;
            nshift_q <= '0;
            nall_q   <= 1'b0;
            nmode_q  <= 1'b0;
            nvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mode_q   <= mode_d;
            ndata_q  <= ndata_d;
            nshift_q <= nshift_d;
            nall_q   <= nall_d;
            nmode_q  <= nmode_d;
            nvalid_q <= nvalid_d;
            err_q    <= err_d;
        end
    end

    assign out_if.norm_data  = ndata_q;
    assign out_if.norm_shift = nshift_q;
    assign out_if.norm_all   = nall_q;
    assign out_if.norm_mode  = nmode_q;
    assign out_if.norm_valid = nvalid_q;
    assign err               = err_q;

endmodule
